// File: rtl/sonar_echo_timer.sv
// sonar_echo_timer
//   Multi-channel ultrasonic ranging engine. Each channel fires a trigger pulse,
//   waits for the echo rising edge and measures the echo high time in whole
//   microseconds. A timeout ends the measurement if the echo never arrives or
//   never falls. All channels are fully independent.
//
// Ports
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-high reset, clears all state
//   start    in   [CHANNELS]       per-channel start request
//   ack      in   [CHANNELS]       per-channel result acknowledge
//   echo     in   [CHANNELS]       raw asynchronous echo pins
//   trig     out  [CHANNELS]       registered trigger outputs
//   busy     out  [CHANNELS]       channel in TRIG, WAIT_ECHO or MEASURE
//   done     out  [CHANNELS]       sticky result-valid flag
//   timeout  out  [CHANNELS]       result ended by timeout (valid with done)
//   width    out  [CHANNELS*WIDTH] results in us, channel c at [c*WIDTH +: WIDTH]
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for start
// TRIG      | trigger pulse high for TRIG_US us
// WAIT_ECHO | waiting for a synchronised echo rising edge
// MEASURE   | counting echo high time in us
// DONE      | result valid, waiting for ack or a new start

module sonar_echo_timer #(
  parameter int CHANNELS   = 4,
  parameter int WIDTH      = 32,
  parameter int CLK_PER_US = 50,
  parameter int TRIG_US    = 10,
  parameter int TIMEOUT_US = 38000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       start,
  input  logic [CHANNELS-1:0]       ack,
  input  logic [CHANNELS-1:0]       echo,
  output logic [CHANNELS-1:0]       trig,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS-1:0]       done,
  output logic [CHANNELS-1:0]       timeout,
  output logic [CHANNELS*WIDTH-1:0] width
);

  localparam int TRIG_CYC = TRIG_US * CLK_PER_US;
  localparam int TW       = $clog2(TRIG_CYC + 1);
  localparam int PW       = $clog2(CLK_PER_US);
  localparam int EW       = $clog2(TIMEOUT_US + 1);

  localparam logic [TW-1:0] TRIG_LOAD = TW'(TRIG_CYC - 1);
  localparam logic [PW-1:0] PRE_MAX   = PW'(CLK_PER_US - 1);
  localparam logic [EW-1:0] EL_LOAD   = EW'(TIMEOUT_US - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_ECHO,
    S_MEASURE,
    S_DONE
  } state_t;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    state_t           state, state_nxt;
    logic [1:0]       sync;
    logic             sync_prev;
    logic [TW-1:0]    trig_cnt, trig_cnt_nxt;
    logic [PW-1:0]    pre, pre_nxt;
    logic [PW-1:0]    el_pre, el_pre_nxt;
    logic [EW-1:0]    el_cnt, el_cnt_nxt;
    logic [WIDTH-1:0] w, w_nxt, w_inc;
    logic             trig_r, trig_nxt;
    logic             done_r, done_nxt;
    logic             to_r, to_nxt;
    logic             echo_s, echo_rise, el_term;

    assign echo_s    = sync[1];
    // A level already high when WAIT_ECHO is entered has sync_prev set, so
    // only a genuine low-to-high transition qualifies.
    assign echo_rise = echo_s & ~sync_prev;
    // Elapsed time is a down-counter pair; both at zero means the timeout
    // budget is used up on this edge.
    assign el_term   = (el_cnt == '0) && (el_pre == '0);
    assign w_inc     = (&w) ? w : w + WIDTH'(1);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync      <= '0;
        sync_prev <= 1'b0;
      end else begin
        sync      <= {sync[0], echo[c]};
        sync_prev <= sync[1];
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state    <= S_IDLE;
        trig_cnt <= '0;
        pre      <= '0;
        el_pre   <= '0;
        el_cnt   <= '0;
        w        <= '0;
        trig_r   <= 1'b0;
        done_r   <= 1'b0;
        to_r     <= 1'b0;
      end else begin
        state    <= state_nxt;
        trig_cnt <= trig_cnt_nxt;
        pre      <= pre_nxt;
        el_pre   <= el_pre_nxt;
        el_cnt   <= el_cnt_nxt;
        w        <= w_nxt;
        trig_r   <= trig_nxt;
        done_r   <= done_nxt;
        to_r     <= to_nxt;
      end
    end

    always_comb begin
      state_nxt    = state;
      trig_cnt_nxt = trig_cnt;
      pre_nxt      = pre;
      el_pre_nxt   = el_pre;
      el_cnt_nxt   = el_cnt;
      w_nxt        = w;
      trig_nxt     = trig_r;
      done_nxt     = done_r;
      to_nxt       = to_r;

      case (state)
        S_IDLE, S_DONE: begin
          if (start[c]) begin
            state_nxt    = S_TRIG;
            trig_nxt     = 1'b1;
            trig_cnt_nxt = TRIG_LOAD;
            done_nxt     = 1'b0;
            to_nxt       = 1'b0;
            w_nxt        = '0;
            pre_nxt      = '0;
          end else if ((state == S_DONE) && ack[c]) begin
            state_nxt = S_IDLE;
            done_nxt  = 1'b0;
            to_nxt    = 1'b0;
          end
        end

        S_TRIG: begin
          if (trig_cnt == '0) begin
            state_nxt  = S_WAIT_ECHO;
            trig_nxt   = 1'b0;
            el_cnt_nxt = EL_LOAD;
            el_pre_nxt = PRE_MAX;
            pre_nxt    = '0;
          end else begin
            trig_cnt_nxt = trig_cnt - TW'(1);
          end
        end

        S_WAIT_ECHO, S_MEASURE: begin
          if (el_term) begin
            state_nxt = S_DONE;
            done_nxt  = 1'b1;
            to_nxt    = 1'b1;
            w_nxt     = '1;
          end else begin
            if (el_pre == '0) begin
              el_pre_nxt = PRE_MAX;
              el_cnt_nxt = el_cnt - EW'(1);
            end else begin
              el_pre_nxt = el_pre - PW'(1);
            end

            if (state == S_WAIT_ECHO) begin
              if (echo_rise) begin
                state_nxt = S_MEASURE;
                pre_nxt   = '0;
                w_nxt     = '0;
              end
            end else begin
              // The exit edge still counts a prescaler step so that H cycles
              // of echo high give exactly floor(H / CLK_PER_US).
              if (pre == PRE_MAX) begin
                pre_nxt = '0;
                w_nxt   = w_inc;
              end else begin
                pre_nxt = pre + PW'(1);
              end
              if (!echo_s) begin
                state_nxt = S_DONE;
                done_nxt  = 1'b1;
                to_nxt    = 1'b0;
              end
            end
          end
        end

        default: state_nxt = S_IDLE;
      endcase
    end

    assign trig[c]                 = trig_r;
    assign busy[c]                 = (state == S_TRIG) || (state == S_WAIT_ECHO) ||
                                     (state == S_MEASURE);
    assign done[c]                 = done_r;
    assign timeout[c]              = to_r;
    assign width[c*WIDTH +: WIDTH] = w;
  end

endmodule

// File: tb/tb_sonar_echo_timer.sv
module tb_sonar_echo_timer;

  localparam int CH       = 2;
  localparam int W        = 16;
  localparam int CPU      = 5;
  localparam int TRIG_US  = 2;
  localparam int TO_US    = 20;
  localparam int TRIG_CYC = TRIG_US * CPU;
  localparam int TO_CYC   = TO_US * CPU;

  logic            clk = 1'b0;
  logic            reset;
  logic [CH-1:0]   start, ack, echo;
  logic [CH-1:0]   trig, busy, done, timeout;
  logic [CH*W-1:0] width;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  sonar_echo_timer #(
    .CHANNELS  (CH),
    .WIDTH     (W),
    .CLK_PER_US(CPU),
    .TRIG_US   (TRIG_US),
    .TIMEOUT_US(TO_US)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .ack    (ack),
    .echo   (echo),
    .trig   (trig),
    .busy   (busy),
    .done   (done),
    .timeout(timeout),
    .width  (width)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: got time-out expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wid(input int ch);
    return 32'(width[ch*W +: W]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_trig(input int ch, output int t_fall);
    int n;
    tick(); start[ch] = 1'b1;
    tick(); start[ch] = 1'b0;
    chk($sformatf("trig_hi%0d", ch), 32'(trig[ch]), 1);
    chk($sformatf("busy_trig%0d", ch), 32'(busy[ch]), 1);
    chk($sformatf("done_clr%0d", ch), 32'(done[ch]), 0);
    chk($sformatf("width_clr%0d", ch), wid(ch), 0);
    n = 1;
    while (trig[ch] && n <= TRIG_CYC + 5) begin
      tick();
      if (trig[ch]) n++;
    end
    chk($sformatf("trig_len%0d", ch), n, TRIG_CYC);
    t_fall = cyc;
  endtask

  task automatic wait_done(input int ch, output int at);
    int k = 0;
    while (!done[ch] && k < 300) begin
      tick();
      k++;
    end
    if (!done[ch]) chk($sformatf("done_wait%0d", ch), 32'(done[ch]), 1);
    at = cyc;
  endtask

  task automatic pulse_echo(input int ch, input int h, output int k);
    echo[ch] = 1'b1;
    k = cyc;
    repeat (h) tick();
    echo[ch] = 1'b0;
  endtask

  task automatic do_ack(input int ch, input int wexp);
    tick(); ack[ch] = 1'b1;
    tick(); ack[ch] = 1'b0;
    chk($sformatf("ack_done%0d", ch), 32'(done[ch]), 0);
    chk($sformatf("ack_to%0d", ch), 32'(timeout[ch]), 0);
    chk($sformatf("ack_hold%0d", ch), wid(ch), wexp);
  endtask

  // Reference: echo high for h raw cycles yields floor(h / CPU) us, with done
  // rising 3 edges after the last high cycle; no echo yields all ones exactly
  // TO_CYC cycles after the trigger falls.
  task automatic run_meas(input int ch, input int d, input int h, input bit no_echo);
    int tf, k, at, wexp;
    do_trig(ch, tf);
    if (no_echo) begin
      wait_done(ch, at);
      chk($sformatf("to_lat%0d", ch), at - tf, TO_CYC);
      chk($sformatf("to_flag%0d", ch), 32'(timeout[ch]), 1);
      wexp = 32'hFFFF;
    end else begin
      repeat (d) tick();
      pulse_echo(ch, h, k);
      wait_done(ch, at);
      chk($sformatf("echo_lat%0d", ch), at - k, h + 3);
      chk($sformatf("echo_to%0d", ch), 32'(timeout[ch]), 0);
      wexp = h / CPU;
    end
    chk($sformatf("width%0d", ch), wid(ch), wexp);
    chk($sformatf("busy_done%0d", ch), 32'(busy[ch]), 0);
    do_ack(ch, wexp);
  endtask

  initial begin
    int tf, k, at;
    int d0, h0, d1, h1;
    bit ne0, ne1;
    start = '0; ack = '0; echo = '0; reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_trig", 32'(trig), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_to", 32'(timeout), 0);
    chk("rst_width", width, 0);

    // reset in the middle of a trigger pulse
    tick(); start[0] = 1'b1;
    tick(); start[0] = 1'b0;
    repeat (3) tick();
    chk("mid_trig", 32'(trig[0]), 1);
    #3 reset = 1'b1;
    #1;
    chk("arst_trig", 32'(trig), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_width", width, 0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) tick();
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_trig", 32'(trig), 0);

    // basic measurement, then async reset clears a held result
    run_meas(0, 3, 37, 1'b0);
    #3 reset = 1'b1;
    #1;
    chk("arst_width_held", width, 0);
    @(posedge clk); #1 reset = 1'b0;

    // no echo on ch1 -> timeout
    run_meas(1, 0, 0, 1'b1);

    // echo already high through trigger end must not count as an edge
    echo[0] = 1'b1;
    repeat (2) tick();
    do_trig(0, tf);
    repeat (3) tick();
    echo[0] = 1'b0;
    repeat (4) tick();
    chk("pre_edge_busy", 32'(busy[0]), 1);
    pulse_echo(0, 12, k);
    wait_done(0, at);
    chk("hi_entry_lat", at - k, 15);
    chk("hi_entry_width", wid(0), 2);
    chk("hi_entry_to", 32'(timeout[0]), 0);
    do_ack(0, 2);

    // start during MEASURE ignored
    do_trig(0, tf);
    repeat (2) tick();
    echo[0] = 1'b1;
    k = cyc;
    repeat (6) tick();
    start[0] = 1'b1;
    tick(); start[0] = 1'b0;
    chk("meas_start_trig", 32'(trig[0]), 0);
    chk("meas_start_busy", 32'(busy[0]), 1);
    repeat (13) tick();
    echo[0] = 1'b0;
    wait_done(0, at);
    chk("meas_start_lat", at - k, 23);
    chk("meas_start_width", wid(0), 4);

    // start and ack together in DONE: start wins
    tick(); start[0] = 1'b1; ack[0] = 1'b1;
    tick(); start[0] = 1'b0; ack[0] = 1'b0;
    chk("sa_done", 32'(done[0]), 0);
    chk("sa_trig", 32'(trig[0]), 1);
    chk("sa_busy", 32'(busy[0]), 1);
    chk("sa_width", wid(0), 0);
    wait_done(0, at);
    chk("sa_to", 32'(timeout[0]), 1);
    chk("sa_to_width", wid(0), 32'hFFFF);
    do_ack(0, 32'hFFFF);

    // concurrent channels
    fork
      run_meas(0, 2, 9, 1'b0);
      run_meas(1, 5, 24, 1'b0);
    join

    // randomized concurrent runs
    for (int it = 0; it < 10; it++) begin
      d0 = $urandom_range(0, 30); h0 = $urandom_range(1, 60);
      d1 = $urandom_range(0, 30); h1 = $urandom_range(1, 60);
      ne0 = ($urandom_range(0, 4) == 0);
      ne1 = ($urandom_range(0, 4) == 0);
      fork
        run_meas(0, d0, h0, ne0);
        run_meas(1, d1, h1, ne1);
      join
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sonar_echo_timer.md
# sonar_echo_timer

Parametrised multi-channel ultrasonic ranging engine: per channel it issues a trigger pulse of fixed microsecond length, waits for the echo rising edge, and measures echo high time in whole microseconds with a timeout. It replaces the free-running single microsecond counter with per-channel, cycle-exact measurement. It sits between the processor's memory-mapped I/O and the sonar sensor pins.

## Interface
Parameters:
- CHANNELS, 4, number of independent sensor channels
- WIDTH, 32, width of each measured-width result
- CLK_PER_US, 50, clk cycles per microsecond (must be ≥ 2)
- TRIG_US, 10, trigger pulse length in µs
- TIMEOUT_US, 38000, max µs from end of trigger to measurement end (must be < 2^WIDTH − 1)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  CHANNELS  per-channel start request, sampled on clk
- ack  in  CHANNELS  per-channel result acknowledge, clears done
- echo  in  CHANNELS  raw asynchronous echo pins
- trig  out  CHANNELS  trigger outputs to sensors (registered)
- busy  out  CHANNELS  high in TRIG, WAIT_ECHO, MEASURE
- done  out  CHANNELS  sticky result-valid flag
- timeout  out  CHANNELS  result ended by timeout; valid while done
- width  out  CHANNELS*WIDTH  flat results, channel c at [c*WIDTH +: WIDTH], µs

## Operation
- Each channel is fully independent: own FSM, own 2-flop echo synchroniser, own sub-µs prescaler (0..CLK_PER_US−1), own µs width counter and own elapsed-µs counter.
- States: IDLE, TRIG, WAIT_ECHO, MEASURE, DONE.
- IDLE/DONE, start=1 → TRIG; clears done, timeout, width, prescaler. start overrides ack in the same cycle.
- DONE, ack=1, start=0 → IDLE; done, timeout cleared; width holds last value.
- TRIG: trig=1; after TRIG_US*CLK_PER_US cycles → WAIT_ECHO, trig=0; elapsed counter and prescaler cleared.
- WAIT_ECHO: waits for rising edge of synchronised echo (synced 1, previous synced 0). Echo already high on entry is not an edge; it must go low then high. Edge → MEASURE; prescaler cleared; width counter cleared.
- MEASURE: width increments by 1 each time the prescaler wraps CLK_PER_US−1→0. Synced echo low → DONE, done=1, timeout=0.
- Elapsed counter increments once per CLK_PER_US cycles in WAIT_ECHO and MEASURE (own prescaler). Reaching TIMEOUT_US in either state → DONE, done=1, timeout=1, width = all ones.
- start in TRIG/WAIT_ECHO/MEASURE ignored; ack outside DONE ignored.
- Width counter saturates at all ones, never wraps.

## Timing
- Reset (async, any state, mid-trigger included): trig, busy, done, timeout, width all 0 immediately; FSM IDLE; synchronisers 0.
- start sampled at edge S → trig and busy high after S; trig high exactly TRIG_US*CLK_PER_US cycles.
- Echo latency: state change occurs at edge E+2 where E is the first edge sampling the new raw echo level (2 sync stages). Both edges delayed equally, so echo held high H cycles gives width = floor(H / CLK_PER_US).
- done, timeout, width update on the same edge as the DONE transition; busy falls on that edge.
- Timeout: DONE entered TIMEOUT_US*CLK_PER_US cycles after WAIT_ECHO entry.
- ack at edge A in DONE → done low after A; start may be issued the following cycle.

## Test plan
Parameters for bench: CHANNELS=2, WIDTH=16, CLK_PER_US=5, TRIG_US=2, TIMEOUT_US=20.
- Reset asserted mid-TRIG on ch0 → trig[0], busy, done, width drop to 0 without a clk edge; FSM returns IDLE.
- start[0] 1 cycle → trig[0] high exactly 10 cycles; echo[0] high 37 cycles → done[0]=1, timeout[0]=0, width ch0=7; ack → done low, width holds 7.
- start[1], echo never rises → done[1]=1 exactly 100 cycles after trig falls, timeout[1]=1, width ch1=16'hFFFF.
- echo[0] held high before and through trig end, falls after 3 cycles, rises again and holds 12 cycles → width=2 (first high ignored).
- start[0] pulsed during MEASURE ignored; start and ack same cycle in DONE → new TRIG starts, done cleared.
- Both channels run concurrently with echo widths 9 and 24 cycles → widths 1 and 4, no cross-channel interference.
